// File: rtl/ddr3_cmd_responder.sv
// DDR3 device-side responder: decodes bus commands, tracks per-bank open/precharge
// state and refresh, serves a 64x16 data array with fixed CAS latency. Define DDR3_RSP_CHECK_EN for legality checks.
module ddr3_cmd_responder #(
    parameter int CL   = 5,
    parameter int tRP  = 3,
    parameter int tRFC = 10
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        CS,
    input  logic        RAS,
    input  logic        CAS,
    input  logic        WE,
    input  logic [14:0] Addr_in,
    input  logic [2:0]  BA_in,
    input  logic [15:0] DQ_in,
    input  logic        LDM,
    input  logic        UDM,
    output logic [15:0] DQ_out,
    output logic        DQ_valid,
    output logic [7:0]  Bank_Open,
    output logic        Busy,
    output logic        Err,
    output logic [2:0]  Err_Code
);

    typedef enum logic [2:0] {
        CMD_MRS = 3'b000,
        CMD_REF = 3'b001,
        CMD_PRE = 3'b010,
        CMD_ACT = 3'b011,
        CMD_WR  = 3'b100,
        CMD_RD  = 3'b101,
        CMD_ZQ  = 3'b110,
        CMD_NOP = 3'b111
    } cmd_e;

    // Counter reaches zero exactly on the edge where ACT becomes legal again
    localparam logic [3:0] TRP_LOAD  = 4'(tRP - 1);
    localparam logic [7:0] TRFC_LOAD = 8'(tRFC);

    logic [7:0]    open_r;
    logic [14:0]   row_r      [8];
    logic [3:0]    trp_cnt_r  [8];
    logic [7:0]    busy_cnt_r;
    logic          busy_r;
    logic          err_r;
    logic [2:0]    err_code_r;
    logic [15:0]   mem_r      [64];
    logic [15:0]   pipe_dat_r [CL];
    logic [CL-1:0] pipe_vld_r;

    cmd_e          cmd_s;
    logic [5:0]    mem_idx_s;
    logic          bank_open_s;
    logic          exec_s;
    logic [2:0]    err_code_s;
    logic          wr_en_s;
    logic          rd_en_s;

    assign cmd_s       = CS ? CMD_NOP : cmd_e'({RAS, CAS, WE});
    assign mem_idx_s   = {BA_in, Addr_in[2:0]};
    assign bank_open_s = open_r[BA_in];

`ifdef DDR3_RSP_CHECK_EN
    logic any_trp_s;
    logic busy_blk_s;

    // The last refresh cycle already accepts commands, so only counts above 1 block
    assign busy_blk_s = (busy_cnt_r > 8'd1);

    // Any bank still inside its precharge window
    always_comb begin
        any_trp_s = 1'b0;
        for (int b = 0; b < 8; b++) begin
            any_trp_s = any_trp_s | (trp_cnt_r[b] != 4'd0);
        end
    end

    // Legality decode; busy dominates, then refresh/tRP, then bank-state errors
    always_comb begin
        err_code_s = 3'd0;
        if (cmd_s == CMD_NOP) begin
            err_code_s = 3'd0;
        end else if (busy_blk_s) begin
            err_code_s = 3'd4;
        end else begin
            case (cmd_s)
                CMD_ACT: begin
                    if (trp_cnt_r[BA_in] != 4'd0) begin
                        err_code_s = 3'd5;
                    end else if (bank_open_s) begin
                        err_code_s = 3'd1;
                    end else begin
                        err_code_s = 3'd0;
                    end
                end
                CMD_RD, CMD_WR: begin
                    if (!bank_open_s) begin
                        err_code_s = 3'd2;
                    end else begin
                        err_code_s = 3'd0;
                    end
                end
                CMD_REF, CMD_MRS, CMD_ZQ: begin
                    if ((|open_r) || any_trp_s) begin
                        err_code_s = 3'd3;
                    end else begin
                        err_code_s = 3'd0;
                    end
                end
                default: err_code_s = 3'd0;
            endcase
        end
    end

    assign exec_s = (err_code_s == 3'd0);
`else
    assign err_code_s = 3'd0;
    assign exec_s     = 1'b1;
`endif

    assign wr_en_s = exec_s && (cmd_s == CMD_WR);
    assign rd_en_s = exec_s && (cmd_s == CMD_RD);

    // Bank open/precharge state, refresh window and error reporting
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            open_r     <= 8'd0;
            busy_cnt_r <= 8'd0;
            busy_r     <= 1'b0;
            err_r      <= 1'b0;
            err_code_r <= 3'd0;
            for (int b = 0; b < 8; b++) begin
                row_r[b]     <= 15'd0;
                trp_cnt_r[b] <= 4'd0;
            end
        end else begin
            err_r      <= (err_code_s != 3'd0);
            err_code_r <= err_code_s;
            for (int b = 0; b < 8; b++) begin
                if (trp_cnt_r[b] != 4'd0) begin
                    trp_cnt_r[b] <= trp_cnt_r[b] - 4'd1;
                end
            end
            if (busy_cnt_r != 8'd0) begin
                busy_cnt_r <= busy_cnt_r - 8'd1;
            end
            busy_r <= (busy_cnt_r > 8'd1);
            if (exec_s) begin
                case (cmd_s)
                    CMD_ACT: begin
                        open_r[BA_in] <= 1'b1;
                        row_r[BA_in]  <= Addr_in;
                    end
                    CMD_PRE: begin
                        for (int b = 0; b < 8; b++) begin
                            if (open_r[b] && (Addr_in[10] || (BA_in == 3'(b)))) begin
                                open_r[b]    <= 1'b0;
                                trp_cnt_r[b] <= TRP_LOAD;
                            end
                        end
                    end
                    CMD_RD, CMD_WR: begin
                        if (Addr_in[10] && bank_open_s) begin
                            open_r[BA_in]    <= 1'b0;
                            trp_cnt_r[BA_in] <= TRP_LOAD;
                        end
                    end
                    CMD_REF: begin
                        busy_cnt_r <= TRFC_LOAD;
                        busy_r     <= 1'b1;
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    // Data array with byte masks; contents survive reset
    always_ff @(posedge CLK) begin
        if (RESET && wr_en_s) begin
            if (!LDM) begin
                mem_r[mem_idx_s][7:0] <= DQ_in[7:0];
            end
            if (!UDM) begin
                mem_r[mem_idx_s][15:8] <= DQ_in[15:8];
            end
        end
    end

    // CAS-latency pipeline: stage 0 captures on the READ edge, last stage drives DQ
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            pipe_vld_r <= {CL{1'b0}};
            for (int i = 0; i < CL; i++) begin
                pipe_dat_r[i] <= 16'd0;
            end
        end else begin
            pipe_vld_r    <= {pipe_vld_r[CL-2:0], rd_en_s};
            pipe_dat_r[0] <= rd_en_s ? mem_r[mem_idx_s] : 16'd0;
            for (int i = 1; i < CL; i++) begin
                pipe_dat_r[i] <= pipe_dat_r[i-1];
            end
        end
    end

    assign DQ_out    = pipe_dat_r[CL-1];
    assign DQ_valid  = pipe_vld_r[CL-1];
    assign Bank_Open = open_r;
    assign Busy      = busy_r;
    assign Err       = err_r;
    assign Err_Code  = err_code_r;

endmodule

// File: tb/tb_ddr3_cmd_responder.sv
// Self-checking bench for ddr3_cmd_responder: directed scenarios plus random
// command streams compared cycle by cycle against an edge-numbered behavioural model.
module tb_ddr3_cmd_responder;

    localparam int CL   = 5;
    localparam int TRP  = 3;
    localparam int TRFC = 10;
`ifdef DDR3_RSP_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    localparam logic [2:0] C_MRS = 3'b000, C_REF = 3'b001, C_PRE = 3'b010, C_ACT = 3'b011;
    localparam logic [2:0] C_WR  = 3'b100, C_RD  = 3'b101, C_ZQ  = 3'b110, C_NOP = 3'b111;

    logic        CLK = 1'b0;
    logic        RESET, CS, RAS, CAS, WE, LDM, UDM;
    logic [14:0] Addr_in;
    logic [2:0]  BA_in;
    logic [15:0] DQ_in;
    logic [15:0] DQ_out;
    logic        DQ_valid, Busy, Err;
    logic [7:0]  Bank_Open;
    logic [2:0]  Err_Code;

    ddr3_cmd_responder #(.CL(CL), .tRP(TRP), .tRFC(TRFC)) dut (
        .CLK(CLK), .RESET(RESET), .CS(CS), .RAS(RAS), .CAS(CAS), .WE(WE),
        .Addr_in(Addr_in), .BA_in(BA_in), .DQ_in(DQ_in), .LDM(LDM), .UDM(UDM),
        .DQ_out(DQ_out), .DQ_valid(DQ_valid), .Bank_Open(Bank_Open),
        .Busy(Busy), .Err(Err), .Err_Code(Err_Code)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic        rst_n;
        logic        cs;
        logic [2:0]  cmd;
        logic [14:0] a;
        logic [2:0]  ba;
        logic [15:0] dq;
        logic        ldm;
        logic        udm;
    } op_t;

    typedef struct {
        int          due;
        logic [15:0] data;
        logic [15:0] known;
    } rd_t;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          edge_n  = 0;
    logic [29:0] obs, exp_v, exp_mask;

    // Model state, expressed in absolute edge numbers rather than counters
    bit          m_open   [8];
    int          m_act_ok [8];
    int          m_busy_end;
    logic [15:0] m_mem    [64];
    logic [15:0] m_known  [64];
    rd_t         m_rdq    [$];

    function automatic op_t mk(input logic [2:0] cmd, input logic [2:0] ba, input logic [14:0] a,
                               input logic [15:0] dq, input logic ldm, input logic udm);
        op_t o;
        o.rst_n = 1'b1; o.cs = 1'b0; o.cmd = cmd; o.a = a; o.ba = ba;
        o.dq = dq; o.ldm = ldm; o.udm = udm;
        return o;
    endfunction

    function automatic op_t nop();
        return mk(C_NOP, 3'd0, 15'd0, 16'd0, 1'b0, 1'b0);
    endfunction

    function automatic op_t rst();
        op_t o;
        o = nop();
        o.rst_n = 1'b0;
        o.cs    = 1'b1;
        return o;
    endfunction

    function automatic op_t rand_op();
        op_t o;
        int  p;
        logic [2:0] c;
        p = int'($urandom_range(0, 99));
        if (p < 20)      c = C_ACT;
        else if (p < 45) c = C_RD;
        else if (p < 70) c = C_WR;
        else if (p < 82) c = C_PRE;
        else if (p < 86) c = C_REF;
        else if (p < 88) c = C_MRS;
        else if (p < 90) c = C_ZQ;
        else             c = C_NOP;
        o = mk(c, 3'($urandom_range(0, 3)), 15'($urandom), 16'($urandom),
               ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0));
        o.a[10] = ($urandom_range(0, 4) == 0);
        o.cs    = ($urandom_range(0, 9) == 0);
        return o;
    endfunction

    task automatic close_bank(input int b);
        if (m_open[b]) begin
            m_open[b]   = 1'b0;
            m_act_ok[b] = edge_n + TRP;
        end
    endtask

    task automatic model_edge(input op_t o);
        logic [2:0]  code;
        logic [7:0]  bo;
        bit          pend, vld;
        int          idx;
        rd_t         r;
        logic [15:0] dq, kn;
        code = 3'd0;
        vld  = 1'b0;
        dq   = 16'd0;
        kn   = 16'h0000;
        idx  = int'({o.ba, o.a[2:0]});
        if (!o.rst_n) begin
            for (int b = 0; b < 8; b++) begin
                m_open[b]   = 1'b0;
                m_act_ok[b] = 0;
            end
            m_busy_end = 0;
            m_rdq.delete();
            exp_v    = 30'd0;
            exp_mask = {30{1'b1}};
        end else begin
            if (!o.cs && o.cmd != C_NOP) begin
                pend = 1'b0;
                for (int b = 0; b < 8; b++) pend |= m_open[b] || (edge_n < m_act_ok[b]);
                if (edge_n < m_busy_end) code = 3'd4;
                else if (o.cmd == C_ACT && edge_n < m_act_ok[o.ba]) code = 3'd5;
                else if ((o.cmd inside {C_REF, C_MRS, C_ZQ}) && pend) code = 3'd3;
                else if (o.cmd == C_ACT && m_open[o.ba]) code = 3'd1;
                else if ((o.cmd inside {C_RD, C_WR}) && !m_open[o.ba]) code = 3'd2;
                if (!CHK) code = 3'd0;
                if (code == 3'd0) begin
                    case (o.cmd)
                        C_ACT: m_open[o.ba] = 1'b1;
                        C_PRE: for (int b = 0; b < 8; b++) if (o.a[10] || b == int'(o.ba)) close_bank(b);
                        C_WR: begin
                            if (!o.ldm) begin m_mem[idx][7:0]  = o.dq[7:0];  m_known[idx][7:0]  = 8'hFF; end
                            if (!o.udm) begin m_mem[idx][15:8] = o.dq[15:8]; m_known[idx][15:8] = 8'hFF; end
                            if (o.a[10]) close_bank(int'(o.ba));
                        end
                        C_RD: begin
                            r.due = edge_n + CL - 1; r.data = m_mem[idx]; r.known = m_known[idx];
                            m_rdq.push_back(r);
                            if (o.a[10]) close_bank(int'(o.ba));
                        end
                        C_REF: m_busy_end = edge_n + TRFC;
                        default: ;
                    endcase
                end
            end
            if (m_rdq.size() > 0 && m_rdq[0].due == edge_n) begin
                r   = m_rdq.pop_front();
                vld = 1'b1;
                kn  = r.known;
                dq  = r.data & kn;
            end
            for (int b = 0; b < 8; b++) bo[b] = m_open[b];
            exp_v    = {vld, dq, bo, (edge_n < m_busy_end), (code != 3'd0), code};
            exp_mask = {1'b1, kn, 8'hFF, 1'b1, 1'b1, 3'b111};
        end
    endtask

    task automatic step(input op_t o);
        @(negedge CLK);
        RESET = o.rst_n; CS = o.cs; {RAS, CAS, WE} = o.cmd;
        Addr_in = o.a; BA_in = o.ba; DQ_in = o.dq; LDM = o.ldm; UDM = o.udm;
        @(posedge CLK);
        edge_n++;
        model_edge(o);
        #1;
        obs = {DQ_valid, DQ_out, Bank_Open, Busy, Err, Err_Code};
    endtask

    task automatic test_reset();
        op_t ops[$];
        ops = '{rst(), rst(), nop(), nop()};
        foreach (ops[i]) begin
            step(ops[i]);
            n_tests++;
            if (((obs ^ exp_v) & exp_mask) !== 30'd0) begin
                n_fail++; $display("FAIL reset step %0d: got %h want %h", i, obs, exp_v);
            end
            if (i < 2) begin
                n_tests++;
                if (obs !== 30'd0) begin n_fail++; $display("FAIL reset_values: got %h want 0", obs); end
            end
        end
    endtask

    task automatic test_write_read();
        op_t ops[$];
        ops.push_back(mk(C_ACT, 3'd2, 15'h0001, 16'h0, 1'b0, 1'b0));
        ops.push_back(mk(C_WR,  3'd2, 15'h0003, 16'hA5C3, 1'b0, 1'b0));
        ops.push_back(mk(C_RD,  3'd2, 15'h0003, 16'h0, 1'b0, 1'b0));
        ops.push_back(mk(C_RD,  3'd2, 15'h0003, 16'h0, 1'b0, 1'b0));
        repeat (6) ops.push_back(nop());
        foreach (ops[i]) begin
            step(ops[i]);
            n_tests++;
            if (((obs ^ exp_v) & exp_mask) !== 30'd0) begin
                n_fail++; $display("FAIL write_read step %0d: got %h want %h", i, obs, exp_v);
            end
            if (i == 5 || i == 8) begin
                n_tests++;
                if (DQ_valid !== 1'b0) begin n_fail++; $display("FAIL rd_latency step %0d: valid got %b want 0", i, DQ_valid); end
            end
            if (i == 6 || i == 7) begin
                n_tests++;
                if (DQ_valid !== 1'b1 || DQ_out !== 16'hA5C3 || Bank_Open !== 8'h04) begin
                    n_fail++; $display("FAIL rd_data step %0d: got v=%b dq=%h bo=%h want v=1 dq=a5c3 bo=04", i, DQ_valid, DQ_out, Bank_Open);
                end
            end
        end
    endtask

    task automatic test_byte_mask();
        op_t ops[$];
        ops.push_back(mk(C_WR, 3'd2, 15'h0005, 16'hFFFF, 1'b0, 1'b0));
        ops.push_back(mk(C_WR, 3'd2, 15'h0005, 16'h0000, 1'b0, 1'b1));
        ops.push_back(mk(C_RD, 3'd2, 15'h0005, 16'h0000, 1'b0, 1'b0));
        repeat (5) ops.push_back(nop());
        foreach (ops[i]) begin
            step(ops[i]);
            n_tests++;
            if (((obs ^ exp_v) & exp_mask) !== 30'd0) begin
                n_fail++; $display("FAIL byte_mask step %0d: got %h want %h", i, obs, exp_v);
            end
            if (i == 6) begin
                n_tests++;
                if (DQ_valid !== 1'b1 || DQ_out !== 16'hFF00) begin
                    n_fail++; $display("FAIL udm_merge: got v=%b dq=%h want v=1 dq=ff00", DQ_valid, DQ_out);
                end
            end
        end
    endtask

    task automatic test_errors();
        op_t ops[$];
        ops.push_back(mk(C_ACT, 3'd0, 15'h0011, 16'h0, 1'b0, 1'b0));
        ops.push_back(mk(C_ACT, 3'd0, 15'h0022, 16'h0, 1'b0, 1'b0));
        ops.push_back(mk(C_RD,  3'd5, 15'h0000, 16'h0, 1'b0, 1'b0));
        repeat (6) ops.push_back(nop());
        foreach (ops[i]) begin
            step(ops[i]);
            n_tests++;
            if (((obs ^ exp_v) & exp_mask) !== 30'd0) begin
                n_fail++; $display("FAIL errors step %0d: got %h want %h", i, obs, exp_v);
            end
            if (i == 1 || i == 2) begin
                n_tests++;
                if (Err_Code !== (CHK ? 3'(i + 1) : 3'd0)) begin
                    n_fail++; $display("FAIL err_code step %0d: got %0d want %0d", i, Err_Code, CHK ? i + 1 : 0);
                end
            end
        end
    endtask

    task automatic test_auto_precharge();
        op_t ops[$];
        ops.push_back(mk(C_ACT, 3'd1, 15'h0010, 16'h0, 1'b0, 1'b0));
        ops.push_back(mk(C_RD,  3'd1, 15'h0402, 16'h0, 1'b0, 1'b0));
        ops.push_back(nop());
        ops.push_back(mk(C_ACT, 3'd1, 15'h0020, 16'h0, 1'b0, 1'b0));
        ops.push_back(mk(C_ACT, 3'd1, 15'h0030, 16'h0, 1'b0, 1'b0));
        repeat (5) ops.push_back(nop());
        foreach (ops[i]) begin
            step(ops[i]);
            n_tests++;
            if (((obs ^ exp_v) & exp_mask) !== 30'd0) begin
                n_fail++; $display("FAIL auto_pre step %0d: got %h want %h", i, obs, exp_v);
            end
            if (i == 3) begin
                n_tests++;
                if (Err_Code !== (CHK ? 3'd5 : 3'd0)) begin n_fail++; $display("FAIL act_in_trp: got %0d want %0d", Err_Code, CHK ? 5 : 0); end
            end
            if (i == 4) begin
                n_tests++;
                if (Err_Code !== 3'd0 || Bank_Open[1] !== 1'b1) begin
                    n_fail++; $display("FAIL act_at_trp: got code=%0d open=%b want code=0 open=1", Err_Code, Bank_Open[1]);
                end
            end
        end
    endtask

    task automatic test_refresh();
        op_t ops[$];
        ops.push_back(mk(C_ACT, 3'd4, 15'h0044, 16'h0, 1'b0, 1'b0));
        ops.push_back(mk(C_REF, 3'd0, 15'h0000, 16'h0, 1'b0, 1'b0));
        ops.push_back(mk(C_PRE, 3'd0, 15'h0400, 16'h0, 1'b0, 1'b0));
        ops.push_back(nop());
        ops.push_back(nop());
        ops.push_back(mk(C_REF, 3'd0, 15'h0000, 16'h0, 1'b0, 1'b0));
        ops.push_back(mk(C_ACT, 3'd3, 15'h0033, 16'h0, 1'b0, 1'b0));
        repeat (12) ops.push_back(nop());
        ops.push_back(mk(C_ACT, 3'd3, 15'h0033, 16'h0, 1'b0, 1'b0));
        ops.push_back(nop());
        foreach (ops[i]) begin
            step(ops[i]);
            n_tests++;
            if (((obs ^ exp_v) & exp_mask) !== 30'd0) begin
                n_fail++; $display("FAIL refresh step %0d: got %h want %h", i, obs, exp_v);
            end
            if (i == 1 || i == 6) begin
                n_tests++;
                if (Err_Code !== (CHK ? ((i == 1) ? 3'd3 : 3'd4) : 3'd0)) begin
                    n_fail++; $display("FAIL ref_err step %0d: got %0d", i, Err_Code);
                end
            end
            if (i == 5 || i == 14 || i == 15) begin
                n_tests++;
                if (Busy !== (i != 15)) begin n_fail++; $display("FAIL busy_window step %0d: got %b want %b", i, Busy, i != 15); end
            end
            if (i == 19) begin
                n_tests++;
                if (Err_Code !== 3'd0 || Bank_Open[3] !== 1'b1) begin
                    n_fail++; $display("FAIL act_after_ref: got code=%0d open=%b want 0/1", Err_Code, Bank_Open[3]);
                end
            end
        end
    endtask

    task automatic test_random();
        op_t o;
        for (int i = 0; i < 400; i++) begin
            o = rand_op();
            step(o);
            n_tests++;
            if (((obs ^ exp_v) & exp_mask) !== 30'd0) begin
                n_fail++; $display("FAIL random step %0d cmd %b ba %0d: got %h want %h", i, o.cmd, o.ba, obs, exp_v);
            end
        end
    endtask

    task automatic test_reset_inflight();
        op_t ops[$];
        int  late_valid;
        late_valid = 0;
        repeat (12) ops.push_back(nop());
        ops.push_back(mk(C_PRE, 3'd0, 15'h0400, 16'h0, 1'b0, 1'b0));
        repeat (3) ops.push_back(nop());
        ops.push_back(mk(C_ACT, 3'd6, 15'h0066, 16'h0, 1'b0, 1'b0));
        ops.push_back(mk(C_RD,  3'd6, 15'h0000, 16'h0, 1'b0, 1'b0));
        ops.push_back(mk(C_RD,  3'd6, 15'h0001, 16'h0, 1'b0, 1'b0));
        ops.push_back(nop());
        ops.push_back(rst());
        ops.push_back(rst());
        repeat (8) ops.push_back(nop());
        foreach (ops[i]) begin
            step(ops[i]);
            n_tests++;
            if (((obs ^ exp_v) & exp_mask) !== 30'd0) begin
                n_fail++; $display("FAIL reset_inflight step %0d: got %h want %h", i, obs, exp_v);
            end
            if (i == 20) begin
                n_tests++;
                if (obs !== 30'd0) begin n_fail++; $display("FAIL mid_reset_values: got %h want 0", obs); end
            end
            if (i > 21 && DQ_valid) late_valid++;
        end
        n_tests++;
        if (late_valid !== 0) begin n_fail++; $display("FAIL dropped_reads: got %0d late valids want 0", late_valid); end
    endtask

    initial begin
        RESET = 1'b0; CS = 1'b1; {RAS, CAS, WE} = C_NOP;
        Addr_in = 15'd0; BA_in = 3'd0; DQ_in = 16'd0; LDM = 1'b0; UDM = 1'b0;
        for (int k = 0; k < 64; k++) m_known[k] = 16'h0000;
        for (int b = 0; b < 8; b++) begin m_open[b] = 1'b0; m_act_ok[b] = 0; end
        m_busy_end = 0;
        test_reset();
        test_write_read();
        test_byte_mask();
        test_errors();
        test_auto_precharge();
        test_refresh();
        test_random();
        test_reset_inflight();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ddr3_cmd_responder.md
# ddr3_cmd_responder

DRAM-side responder for the DDR3 command/data bus driven by the team's controller state machine. Samples CS/RAS/CAS/WE, address, bank and DQ each CLK rising edge, decodes the DDR3 command, tracks open/closed state of all 8 banks, enforces precharge and refresh timing, and stores or returns data with a fixed CAS latency. It sits in the testbench and FPGA loopback builds as the device end of the controller interface.

## Interface
- CL, 5, CAS latency in cycles from READ sample to DQ_valid (2..15)
- tRP, 3, cycles after PRE or auto-precharge before ACT to that bank is legal (1..15)
- tRFC, 10, cycles Busy stays high after REF (1..255)
- CLK  in  1  clock, all sampling on rising edge
- RESET  in  1  asynchronous, active-low reset
- CS, RAS, CAS, WE  in  1 each  active-low command pins
- Addr_in  in  15  row (ACT), column + A10 auto-precharge / A10 all-banks (PRE)
- BA_in  in  3  bank address
- DQ_in  in  16  write data, sampled with WRITE
- LDM, UDM  in  1 each  byte masks, 1 = keep stored byte
- DQ_out  out  16  read data
- DQ_valid  out  1  DQ_out holds read data this cycle
- Bank_Open  out  8  bit n = bank n has an open row
- Busy  out  1  refresh in progress
- Err  out  1  one-cycle pulse, illegal command seen
- Err_Code  out  3  reason, valid while Err=1, else 0

## Operation
- Decode when CS=0 ({RAS,CAS,WE}): 011 ACT, 101 READ, 100 WRITE, 010 PRE, 001 REF, 000 MRS, 110 ZQ, 111 NOP. CS=1 = deselect (NOP).
- Per bank: open bit, 15-bit row register, 4-bit tRP counter.
- ACT: legal if bank closed and its tRP counter 0 → open bit set, row latched.
- PRE: A10=0 closes BA_in bank, A10=1 closes all open banks; each closed bank loads tRP. PRE to a closed bank is a legal no-op.
- WRITE: legal if bank open → mem[{BA_in, Addr_in[2:0]}] updated; DQ_in[7:0] unless LDM, DQ_in[15:8] unless UDM. 64x16 array, row ignored (aliasing intentional).
- READ: legal if bank open → mem entry enters a CL-deep pipeline.
- RD/WR with Addr_in[10]=1: access performed, then bank closes and loads tRP.
- REF: legal only if all banks closed and all tRP counters 0 → Busy high for tRFC cycles.
- MRS, ZQ: accepted, no state change; legal only with all banks closed.
- Illegal command: no state change, Err=1 next cycle. Codes: 1 ACT to open bank; 2 RD/WR to closed bank; 3 REF/MRS/ZQ with bank open or tRP pending; 4 any non-NOP while Busy; 5 ACT during bank's tRP.
- Priority when several apply: 4, then 3/5, then 1/2.

## Timing
- Reset (RESET=0, async): DQ_out=0, DQ_valid=0, Bank_Open=0, Busy=0, Err=0, Err_Code=0, all tRP counters 0, read pipeline cleared. Memory array not reset.
- Command at edge t: Bank_Open/Busy/Err reflect it after edge t (visible cycle t+1).
- READ at edge t: DQ_valid=1 and DQ_out valid in the cycle after edge t+CL-1 (i.e. CL cycles later); back-to-back READs give contiguous DQ_valid.
- WRITE at t, READ same location at t+1: returns new data.
- PRE at t: ACT to that bank legal from edge t+tRP; earlier → code 5.
- REF at t: Busy=1 for cycles t+1..t+tRFC; command legal from edge t+tRFC.
- Reset mid-operation: in-flight reads dropped, no DQ_valid after release.

## Configuration
- DDR3_RSP_CHECK_EN defined: legality checks and Err/Err_Code as above.
- Undefined: Err and Err_Code tied 0; every decoded command executes unconditionally (ACT overwrites row, RD/WR to closed bank still access memory, REF always starts Busy); tRP counters still run but are not checked.

## Test plan
- Reset, ACT bank 2 row 0x0001, WRITE col 3 DQ 0xA5C3, READ col 3 → DQ_valid exactly 5 cycles after READ, DQ_out=0xA5C3, Bank_Open=0x04.
- WRITE 0xFFFF, then WRITE 0x0000 with UDM=1 same column, READ → 0xFF00.
- ACT bank 0 twice → Err=1, Err_Code=1, row unchanged; READ bank 5 closed → Err_Code=2, no DQ_valid.
- READ with A10=1 on bank 1, ACT bank 1 two cycles later → Err_Code=5; ACT at tRP → accepted, Bank_Open[1]=1.
- REF with bank 4 open → Err_Code=3; PRE all, wait tRP, REF → Busy high 10 cycles, ACT during Busy → Err_Code=4.
- Two READs issued, RESET asserted 2 cycles later → outputs at reset values, no DQ_valid after release.
